// File: rtl/snn_pkg.sv
// Shared constants for the spiking-network blocks: synapse FSM encoding,
// default timing parameters and the decay arithmetic.
package snn_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REFRACT = 2'd1;
  localparam logic [1:0] ST_DECAY   = 2'd2;

  localparam int         REFRACT_CYCLES_DEF = 4;
  localparam int         DECAY_PERIOD_DEF   = 8;
  localparam logic [7:0] WEIGHT_RST_DEF     = 8'h10;

  // One decay step. The minimum step of 1 guarantees that a non-zero
  // current always reaches zero eventually, whatever the shift.
  function automatic logic [7:0] decay_step(input logic [7:0] cur, input logic [2:0] shift);
    logic [7:0] d;
    d = cur >> shift;
    if (d == 8'd0 && cur != 8'd0) d = 8'd1;
    return cur - d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..PERIOD-1 counter; tick is high on the terminal count while enabled.
module tick_prescaler #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int             CW   = $clog2(PERIOD);
  localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (clr || tick) count <= '0;
    else if (en)         count <= count + CW'(1);
  end

endmodule

// File: rtl/spike_synapse.sv
// Synapse: weighted spike accumulation with refractory window and exponential decay.
module spike_synapse
  import snn_pkg::*;
#(
  parameter int         REFRACT_CYCLES = REFRACT_CYCLES_DEF,
  parameter int         DECAY_PERIOD   = DECAY_PERIOD_DEF,
  parameter logic [7:0] WEIGHT_RST     = WEIGHT_RST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spike_in,
  input  logic [7:0] weight_in,
  input  logic       weight_load,
  input  logic [2:0] decay_shift,
  output logic [7:0] current_out,
  output logic       busy,
  output logic       refractory,
  output logic       dropped,
  output logic       saturated
);

  localparam int            RW      = $clog2(REFRACT_CYCLES + 1);
  localparam logic [RW-1:0] RC_LOAD = RW'(REFRACT_CYCLES - 1);

  logic [1:0]    state, state_next;
  logic [RW-1:0] refr_cnt, refr_next;
  logic [7:0]    weight, current_next;
  logic [8:0]    sum;
  logic          accept, tick;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    accept       = spike_in && (state != ST_REFRACT);
    sum          = {1'b0, current_out} + {1'b0, weight};
    current_next = current_out;
    state_next   = state;
    refr_next    = refr_cnt;
    if (accept) begin
      // An accepted spike wins over a coincident decay step.
      current_next = sum[8] ? 8'hFF : sum[7:0];
      state_next   = ST_REFRACT;
      refr_next    = RC_LOAD;
    end else begin
      if (tick) current_next = decay_step(current_out, decay_shift);
      case (state)
        ST_IDLE: ;
        ST_REFRACT: begin
          if (refr_cnt == '0) state_next = (current_next != 8'd0) ? ST_DECAY : ST_IDLE;
          else                refr_next  = refr_cnt - RW'(1);
        end
        ST_DECAY: if (current_next == 8'd0) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  tick_prescaler #(.PERIOD(DECAY_PERIOD)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || (state_next == ST_IDLE)),
    .en    (state != ST_IDLE),
    .tick  (tick)
  );

  // Status outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      refr_cnt    <= '0;
      weight      <= WEIGHT_RST;
      current_out <= 8'd0;
      busy        <= 1'b0;
      refractory  <= 1'b0;
      dropped     <= 1'b0;
      saturated   <= 1'b0;
    end else begin
      state       <= state_next;
      refr_cnt    <= refr_next;
      current_out <= current_next;
      if (weight_load) weight <= weight_in;
      busy        <= (state_next != ST_IDLE);
      refractory  <= (state_next == ST_REFRACT);
      dropped     <= spike_in && (state == ST_REFRACT);
      saturated   <= accept && sum[8];
    end
  end

endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: cycle model feeding a scoreboard plus directed scenarios.
module tb_spike_synapse;

  localparam int RC = 4;
  localparam int DP = 8;
  localparam int S_I = 0, S_R = 1, S_D = 2;

  typedef struct {
    logic [7:0] cur;
    logic       busy;
    logic       refr;
    logic       drop;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] weight_in = 8'h00;
  logic       weight_load = 1'b0;
  logic [2:0] decay_shift = 3'd1;
  logic [7:0] current_out;
  logic       busy, refractory, dropped, saturated;

  spike_synapse dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .weight_in   (weight_in),
    .weight_load (weight_load),
    .decay_shift (decay_shift),
    .current_out (current_out),
    .busy        (busy),
    .refractory  (refractory),
    .dropped     (dropped),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  int   m_st, m_cnt, m_pre, m_cur, m_w;
  int   ds_val = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_decay(input int c, input int s);
    int d;
    d = (s == 0) ? c : c / (1 << s);
    if (d == 0 && c > 0) d = 1;
    return d;
  endfunction

  task automatic model_reset();
    m_st = S_I; m_cnt = 0; m_pre = 0; m_cur = 0; m_w = 'h10;
  endtask

  // One clock: drive inputs, advance the model, push its prediction, compare after the edge.
  task automatic step(input logic sp, input logic wl, input logic [7:0] wi);
    exp_t e;
    int   sum, old_st;
    bit   acc, tk, drp, sat;
    spike_in = sp; weight_load = wl; weight_in = wi; decay_shift = 3'(ds_val);
    acc = sp && (m_st != S_R);
    tk  = (m_st != S_I) && (m_pre == DP - 1);
    drp = sp && (m_st == S_R);
    sat = 0;
    old_st = m_st;
    if (acc) begin
      sum = m_cur + m_w;
      sat = (sum > 255);
      m_cur = sat ? 255 : sum;
      m_st = S_R; m_cnt = RC - 1; m_pre = 0;
    end else begin
      if (tk) m_cur = m_cur - model_decay(m_cur, ds_val);
      if (m_st == S_R) begin
        if (m_cnt == 0) m_st = (m_cur != 0) ? S_D : S_I;
        else m_cnt--;
      end else if (m_st == S_D && m_cur == 0) begin
        m_st = S_I;
      end
      if (m_st == S_I) m_pre = 0;
      else if (old_st != S_I) m_pre = tk ? 0 : m_pre + 1;
    end
    if (wl) m_w = wi;
    e.cur = 8'(m_cur); e.busy = (m_st != S_I); e.refr = (m_st == S_R);
    e.drop = drp; e.sat = sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    spike_in = 1'b0; weight_load = 1'b0;
    e = sb.pop_front();
    check("current_out", 32'(current_out), 32'(e.cur));
    check("busy",        32'(busy),        32'(e.busy));
    check("refractory",  32'(refractory),  32'(e.refr));
    check("dropped",     32'(dropped),     32'(e.drop));
    check("saturated",   32'(saturated),   32'(e.sat));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic settle();
    for (int i = 0; i < 3000 && m_st != S_I; i++) step(1'b0, 1'b0, 8'h00);
    idle(2);
  endtask

  // Asynchronous reset held across one rising edge, released away from the edge.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_cur"},  32'(current_out), 32'h0);
    check({tag, "_busy"}, 32'(busy),        32'h0);
    check({tag, "_refr"}, 32'(refractory),  32'h0);
    check({tag, "_drop"}, 32'(dropped),     32'h0);
    check({tag, "_sat"},  32'(saturated),   32'h0);
    @(posedge clk);
    #1;
    check({tag, "_hold_busy"}, 32'(busy), 32'h0);
    rst_n = 1'b1;
  endtask

  int n_drop, n_refr, n_sat;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    pulse_reset("reset");
    idle(2);

    // Single spike, weight 0x40, halving every 8 cycles.
    ds_val = 1;
    step(1'b0, 1'b1, 8'h40);
    step(1'b1, 1'b0, 8'h00);
    check("s1_first", 32'(current_out), 32'h40);
    for (int k = 1; k <= 7; k++) begin
      idle(DP);
      check("s1_decay", 32'(current_out), 32'h40 >> k);
    end
    check("s1_busy_end", 32'(busy), 32'h0);
    settle();

    // Back-to-back spikes: second is dropped, refractory window is 4 cycles.
    step(1'b0, 1'b1, 8'h30);
    n_drop = 0; n_refr = 0;
    step(1'b1, 1'b0, 8'h00);
    n_refr += refractory;
    step(1'b1, 1'b0, 8'h00);
    n_refr += refractory; n_drop += dropped;
    check("s2_cur", 32'(current_out), 32'h30);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      n_refr += refractory; n_drop += dropped;
    end
    check("s2_dropped_cnt", 32'(n_drop), 32'd1);
    check("s2_refr_cycles", 32'(n_refr), 32'd4);
    settle();

    // Saturation: 0xC0 twice, 5 cycles apart.
    step(1'b0, 1'b1, 8'hC0);
    n_sat = 0;
    step(1'b1, 1'b0, 8'h00);
    n_sat += saturated;
    check("s3_first", 32'(current_out), 32'hC0);
    idle(4);
    n_sat += saturated;
    step(1'b1, 1'b0, 8'h00);
    n_sat += saturated;
    check("s3_second", 32'(current_out), 32'hFF);
    idle(3);
    n_sat += saturated;
    check("s3_sat_cnt", 32'(n_sat), 32'd1);
    settle();

    // Weight load coinciding with a spike uses the old weight.
    step(1'b0, 1'b1, 8'h10);
    step(1'b1, 1'b1, 8'h05);
    check("s4_old_weight", 32'(current_out), 32'h10);
    idle(4);
    step(1'b1, 1'b0, 8'h00);
    check("s4_new_weight", 32'(current_out), 32'h15);
    settle();

    // Reset during DECAY with current 0x20; weight returns to its reset value.
    step(1'b0, 1'b1, 8'h20);
    step(1'b1, 1'b0, 8'h00);
    idle(5);
    check("s5_in_decay", 32'({busy, refractory}), 32'b10);
    check("s5_cur_pre", 32'(current_out), 32'h20);
    pulse_reset("s5_reset");
    step(1'b1, 1'b0, 8'h00);
    check("s5_weight_rst", 32'(current_out), 32'h10);
    settle();

    // decay_shift 0 clears the current at the first decay step.
    ds_val = 0;
    step(1'b0, 1'b1, 8'h7F);
    step(1'b1, 1'b0, 8'h00);
    idle(DP - 1);
    check("s6_before", 32'(current_out), 32'h7F);
    idle(1);
    check("s6_cleared", 32'(current_out), 32'h00);
    check("s6_busy", 32'(busy), 32'h0);
    settle();

    // Random traffic against the model, including shift changes mid-decay.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) ds_val = $urandom_range(0, 7);
      step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
